icache_direct: RTL and testbench

ICACHE_DIRECT -- requirements
Module: icache_direct

---
 rtl/icache_direct_if.sv | 23 ++
 rtl/icache_direct.sv | 95 +++++++++
 tb/tb_icache_direct.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/icache_direct_if.sv
// Fetch-side (datapath) and memory-side signals of the direct-mapped instruction cache.
// The cache uses the slave view; the requester/memory model uses the master view.
interface icache_direct_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iflush, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iflush, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-set instruction cache with a zero-latency hit path
// and a two-state IDLE/FETCH miss handler.
module icache_direct #(
  parameter int NSETS = 16
) (
  input  logic           CLK,
  input  logic           nRST,
  icache_direct_if.slave bus
);

  localparam int IB = $clog2(NSETS);
  localparam int TW = 30 - IB;

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [NSETS-1:0] valid_q, valid_d;
  logic [TW-1:0]    tag_q  [NSETS];
  logic [31:0]      data_q [NSETS];

  logic [IB-1:0] idx_s;
  logic [TW-1:0] tag_s;
  logic          hit_s;
  logic          fill_s;
  logic          unused_ok_s;

  assign idx_s       = bus.imemaddr[IB+1:2];
  assign tag_s       = bus.imemaddr[31:IB+2];
  assign unused_ok_s = ^bus.imemaddr[1:0];

  // Next-state, hit detection and fill decision; flush overrides everything
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    hit_s   = 1'b0;
    fill_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.imemREN && !bus.iflush && valid_q[idx_s] && (tag_q[idx_s] == tag_s)) begin
          hit_s = 1'b1;
        end else if (bus.imemREN) begin
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        // Fill completes whenever memory answers, even if the request was dropped
        if (!bus.iwait) begin
          fill_s  = 1'b1;
          state_d = IDLE;
        end else if (!bus.imemREN) begin
          state_d = IDLE;
        end else begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.iflush) begin
      state_d = IDLE;
      valid_d = '0;
      fill_s  = 1'b0;
    end else if (fill_s) begin
      valid_d[idx_s] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  assign bus.ihit     = hit_s;
  assign bus.imemload = hit_s ? data_q[idx_s] : 32'd0;
  assign bus.iREN     = (state_q == FETCH);
  assign bus.iaddr    = (state_q == FETCH) ? {bus.imemaddr[31:2], 2'b00} : 32'd0;

  // State and valid bits, cleared asynchronously so a pending fetch is dropped at once
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  // Tag/data storage; contents are meaningless until the matching valid bit is set
  always_ff @(posedge CLK) begin
    if (fill_s) begin
      tag_q[idx_s]  <= tag_s;
      data_q[idx_s] <= bus.iload;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed vector table, hand sequences for abort/flush/reset,
// then random traffic against a set-indexed reference model.
module tb_icache_direct;

  localparam int NSETS = 16;

  logic CLK;
  logic nRST;
  int   errors;
  int   checks;

  icache_direct_if bus ();

  icache_direct #(.NSETS(NSETS)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        fl;
    logic        w;
    logic [31:0] ld;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_iren;
    logic [31:0] e_iaddr;
  } vec_t;

  vec_t tbl [19];

  // Reference model: what each set holds, as whole word addresses
  bit          m_valid [NSETS];
  int unsigned m_word  [NSETS];
  logic [31:0] m_data  [NSETS];
  bit          m_busy;

  task automatic model_clear();
    for (int i = 0; i < NSETS; i++) m_valid[i] = 1'b0;
    m_busy = 1'b0;
  endtask

  task automatic model_predict(input logic ren, input logic [31:0] a, input logic fl,
                               output logic h, output logic [31:0] l,
                               output logic r, output logic [31:0] ia);
    int unsigned w;
    int unsigned s;
    w  = a / 4;
    s  = w % NSETS;
    h  = !m_busy && ren && !fl && m_valid[s] && (m_word[s] == w);
    l  = h ? m_data[s] : 32'd0;
    r  = m_busy;
    ia = m_busy ? (a / 4) * 4 : 32'd0;
  endtask

  task automatic model_edge(input logic ren, input logic [31:0] a, input logic fl,
                            input logic w, input logic [31:0] ld, input logic was_hit);
    int unsigned s;
    s = (a / 4) % NSETS;
    if (fl) begin
      model_clear();
    end else if (m_busy) begin
      if (!w) begin
        m_valid[s] = 1'b1;
        m_word[s]  = a / 4;
        m_data[s]  = ld;
        m_busy     = 1'b0;
      end else if (!ren) begin
        m_busy = 1'b0;
      end
    end else if (ren && !was_hit) begin
      m_busy = 1'b1;
    end
  endtask

  task automatic cmp(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", nm, f, act, exp);
    end
  endtask

  task automatic chk(input string nm, input logic h, input logic [31:0] l,
                     input logic r, input logic [31:0] ia);
    cmp(nm, "ihit", {31'd0, bus.ihit}, {31'd0, h});
    cmp(nm, "imemload", bus.imemload, l);
    cmp(nm, "iREN", {31'd0, bus.iREN}, {31'd0, r});
    cmp(nm, "iaddr", bus.iaddr, ia);
  endtask

  task automatic apply(input logic ren, input logic [31:0] a, input logic fl,
                       input logic w, input logic [31:0] ld);
    @(negedge CLK);
    bus.imemREN  = ren;
    bus.imemaddr = a;
    bus.iflush   = fl;
    bus.iwait    = w;
    bus.iload    = ld;
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST         = 1'b0;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0040;
    bus.iflush   = 1'b0;
    bus.iwait    = 1'b1;
    bus.iload    = 32'd0;
    #1;
    chk("reset", 1'b0, 32'd0, 1'b0, 32'd0);
    bus.imemREN = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    model_clear();
  endtask

  initial begin
    logic        eh, er;
    logic [31:0] el, eia;
    logic        ren, fl, w;
    logic [31:0] a, ld;

    errors = 0;
    checks = 0;
    nRST   = 1'b0;
    model_clear();

    // ren addr fl w ld | hit load iren iaddr
    tbl[0]  = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    tbl[1]  = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40};
    tbl[2]  = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40};
    tbl[3]  = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40};
    tbl[4]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h8C220004,  1'b0, 32'h0,         1'b1, 32'h40};
    tbl[5]  = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h0,         1'b1, 32'h8C220004,  1'b0, 32'h0};
    tbl[6]  = '{1'b1, 32'h42, 1'b0, 1'b1, 32'h0,         1'b1, 32'h8C220004,  1'b0, 32'h0};
    tbl[7]  = '{1'b1, 32'h80, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    tbl[8]  = '{1'b1, 32'h80, 1'b0, 1'b0, 32'h11111111,  1'b0, 32'h0,         1'b1, 32'h80};
    tbl[9]  = '{1'b1, 32'h80, 1'b0, 1'b1, 32'h0,         1'b1, 32'h11111111,  1'b0, 32'h0};
    tbl[10] = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    tbl[11] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h8C220004,  1'b0, 32'h0,         1'b1, 32'h40};
    tbl[12] = '{1'b0, 32'h40, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    tbl[13] = '{1'b1, 32'h44, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    tbl[14] = '{1'b1, 32'h48, 1'b0, 1'b0, 32'h22,        1'b0, 32'h0,         1'b1, 32'h48};
    tbl[15] = '{1'b1, 32'h48, 1'b0, 1'b1, 32'h0,         1'b1, 32'h22,        1'b0, 32'h0};
    tbl[16] = '{1'b1, 32'h44, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    tbl[17] = '{1'b0, 32'h44, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h44};
    tbl[18] = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h0,         1'b1, 32'h8C220004,  1'b0, 32'h0};

    do_reset();
    for (int i = 0; i < 19; i++) begin
      apply(tbl[i].ren, tbl[i].addr, tbl[i].fl, tbl[i].w, tbl[i].ld);
      chk($sformatf("vec%0d", i), tbl[i].e_hit, tbl[i].e_load, tbl[i].e_iren, tbl[i].e_iaddr);
    end

    // Abort: dropping the request while memory is busy leaves the set unfilled
    apply(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);          chk("abort.miss",   1'b0, 32'h0, 1'b0, 32'h0);
    apply(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);          chk("abort.fetch",  1'b0, 32'h0, 1'b1, 32'h100);
    apply(1'b0, 32'h100, 1'b0, 1'b1, 32'h0);          chk("abort.drop",   1'b0, 32'h0, 1'b1, 32'h100);
    apply(1'b0, 32'h100, 1'b0, 1'b1, 32'h0);          chk("abort.idle",   1'b0, 32'h0, 1'b0, 32'h0);
    apply(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);          chk("abort.remiss", 1'b0, 32'h0, 1'b0, 32'h0);
    apply(1'b1, 32'h100, 1'b0, 1'b0, 32'hAAAA0001);   chk("abort.fill",   1'b0, 32'h0, 1'b1, 32'h100);
    apply(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);          chk("abort.hit",    1'b1, 32'hAAAA0001, 1'b0, 32'h0);

    // Flush colliding with a fill, then flush masking a hit
    apply(1'b1, 32'h208, 1'b0, 1'b1, 32'h0);          chk("flush.miss",    1'b0, 32'h0, 1'b0, 32'h0);
    apply(1'b1, 32'h208, 1'b1, 1'b0, 32'hBBBB0002);   chk("flush.coll",    1'b0, 32'h0, 1'b1, 32'h208);
    apply(1'b1, 32'h208, 1'b0, 1'b1, 32'h0);          chk("flush.nohit",   1'b0, 32'h0, 1'b0, 32'h0);
    apply(1'b0, 32'h208, 1'b0, 1'b1, 32'h0);          chk("flush.abort",   1'b0, 32'h0, 1'b1, 32'h208);
    apply(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);          chk("flush.old100",  1'b0, 32'h0, 1'b0, 32'h0);
    apply(1'b1, 32'h100, 1'b0, 1'b0, 32'hCCCC0003);   chk("flush.refill",  1'b0, 32'h0, 1'b1, 32'h100);
    apply(1'b1, 32'h100, 1'b1, 1'b1, 32'h0);          chk("flush.hitmask", 1'b0, 32'h0, 1'b0, 32'h0);
    apply(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);          chk("flush.after",   1'b0, 32'h0, 1'b0, 32'h0);
    apply(1'b0, 32'h100, 1'b0, 1'b1, 32'h0);          chk("flush.abort2",  1'b0, 32'h0, 1'b1, 32'h100);

    // Reset arriving in the very cycle a fill would complete
    apply(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);           chk("rst.miss",   1'b0, 32'h0, 1'b0, 32'h0);
    apply(1'b1, 32'h40, 1'b0, 1'b0, 32'h8C220004);    chk("rst.fill",   1'b0, 32'h0, 1'b1, 32'h40);
    apply(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);           chk("rst.hit",    1'b1, 32'h8C220004, 1'b0, 32'h0);
    apply(1'b1, 32'h300, 1'b0, 1'b1, 32'h0);          chk("rst.miss2",  1'b0, 32'h0, 1'b0, 32'h0);
    apply(1'b1, 32'h300, 1'b0, 1'b0, 32'hDDDD0004);   chk("rst.fetch",  1'b0, 32'h0, 1'b1, 32'h300);
    #1 nRST = 1'b0;
    #1 chk("rst.mid", 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge CLK);
    bus.imemREN = 1'b0;
    nRST        = 1'b1;
    apply(1'b1, 32'h300, 1'b0, 1'b1, 32'h0);          chk("rst.nofill", 1'b0, 32'h0, 1'b0, 32'h0);
    apply(1'b0, 32'h300, 1'b0, 1'b1, 32'h0);          chk("rst.abort",  1'b0, 32'h0, 1'b1, 32'h300);
    apply(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);           chk("rst.old40",  1'b0, 32'h0, 1'b0, 32'h0);

    // Random traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      ren = ($urandom % 4) != 0;
      a   = $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1) a = a | 32'h1000_0000;
      fl  = ($urandom % 50) == 0;
      w   = ($urandom % 3) != 0;
      ld  = $urandom;
      apply(ren, a, fl, w, ld);
      model_predict(ren, a, fl, eh, el, er, eia);
      chk($sformatf("rnd%0d", i), eh, el, er, eia);
      model_edge(ren, a, fl, w, ld, eh);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
